// File: rtl/sys_defs_pkg.sv
// Shared front-end definitions: PC and instruction types, the NOOP encoding and the fetch FSM states.
package sys_defs;

    typedef logic [63:0] PC;
    typedef logic [31:0] INSTRUCTION;

    // RISC-V canonical NOP (addi x0, x0, 0), driven on lanes that carry no instruction
    localparam INSTRUCTION NOOP_INST = 32'h0000_0013;

    typedef enum logic {
        FETCH = 1'b0,
        DRAIN = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/fetch_issue_unit_lane_select.sv
// fetch_lane_select: combinational issue-count, taken truncation, lane muxing and next-PC selection
// for one 8-byte fetch packet.
module fetch_lane_select
    import sys_defs::*;
#(
    parameter int PC_W = 64
) (
    input  logic [PC_W-1:0]   fetch_pc,
    input  logic [1:0]        ib_nAvai,
    input  logic [1:0]        bp_pred_taken,
    input  logic [2*PC_W-1:0] bp_pred_NPC,
    input  logic [63:0]       rsp_data,
    input  logic              issue_en,
    output logic [1:0]        n_issue,
    output logic [1:0]        lane_valid,
    output logic [63:0]       lane_inst,
    output logic [2*PC_W-1:0] lane_pc,
    output logic [2*PC_W-1:0] lane_npc,
    output logic [PC_W-1:0]   next_pc
);

    logic [1:0]      avail;
    logic [PC_W-1:0] pc0;
    logic [PC_W-1:0] pc1;
    INSTRUCTION      inst0;
    INSTRUCTION      inst1;

    assign pc0      = fetch_pc;
    assign pc1      = fetch_pc + PC_W'(4);
    assign lane_pc  = {pc1, pc0};
    assign lane_npc = {pc1 + PC_W'(4), pc0 + PC_W'(4)};

    // An odd fetch PC leaves only slot 1 of the packet, which moves down to lane 0
    assign inst0 = fetch_pc[2] ? rsp_data[63:32] : rsp_data[31:0];
    assign inst1 = rsp_data[63:32];

    always_comb begin
        avail   = fetch_pc[2] ? 2'd1 : 2'd2;
        n_issue = (ib_nAvai < avail) ? ib_nAvai : avail;
        if (!issue_en) begin
            n_issue = 2'd0;
        end
        // A predicted-taken lane 0 ends the packet; lane 1 would be off the predicted path
        if (n_issue == 2'd2 && bp_pred_taken[0]) begin
            n_issue = 2'd1;
        end
    end

    always_comb begin
        lane_valid = 2'b00;
        next_pc    = fetch_pc;
        case (n_issue)
            2'd1: begin
                lane_valid = 2'b01;
                next_pc    = bp_pred_taken[0] ? bp_pred_NPC[PC_W-1:0] : pc0 + PC_W'(4);
            end
            2'd2: begin
                lane_valid = 2'b11;
                next_pc    = bp_pred_taken[1] ? bp_pred_NPC[2*PC_W-1:PC_W] : pc0 + PC_W'(8);
            end
            default: begin
                lane_valid = 2'b00;
                next_pc    = fetch_pc;
            end
        endcase
    end

    assign lane_inst = {lane_valid[1] ? inst1 : NOOP_INST,
                        lane_valid[0] ? inst0 : NOOP_INST};

endmodule

// File: rtl/fetch_issue_unit.sv
// fetch_issue_unit: 2-way fetch front end with mispredict redirect and stale-response draining.
// Optional FETCH_STATS_EN adds saturating performance counters as extra output ports.
module fetch_issue_unit
    import sys_defs::*;
#(
    parameter logic [63:0] RESET_PC = 64'h0,
    parameter int          PC_W     = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              br_pred_wrong,
    input  logic [PC_W-1:0]   br_recover_pc,
    input  logic [1:0]        ib_nAvai,
    input  logic [1:0]        bp_pred_taken,
    input  logic [2*PC_W-1:0] bp_pred_NPC,
    output logic              icache_req,
    output logic [PC_W-1:0]   icache_addr,
    input  logic              icache_rsp_valid,
    input  logic [63:0]       icache_rsp_data,
    output logic [63:0]       if_inst_out,
    output logic [2*PC_W-1:0] if_pc_out,
    output logic [2*PC_W-1:0] if_not_taken_NPC,
    output logic [1:0]        if_valid_out
`ifdef FETCH_STATS_EN
    ,
    output logic [31:0]       stat_fetched,
    output logic [31:0]       stat_miss_cycles,
    output logic [31:0]       stat_ib_full_cycles,
    output logic [31:0]       stat_redirects
`endif
);

    fetch_state_t    state;
    logic [PC_W-1:0] fetch_pc;
    logic [PC_W-1:0] drain_pc;
    logic [PC_W-1:0] next_pc;
    logic [1:0]      n_issue;
    logic            issue_en;

    assign issue_en    = !reset && state == FETCH && icache_rsp_valid && !br_pred_wrong;
    assign icache_req  = !reset;
    assign icache_addr = {fetch_pc[PC_W-1:3], 3'b000};

    fetch_lane_select #(.PC_W(PC_W)) u_lane_select (
        .fetch_pc      (fetch_pc),
        .ib_nAvai      (ib_nAvai),
        .bp_pred_taken (bp_pred_taken),
        .bp_pred_NPC   (bp_pred_NPC),
        .rsp_data      (icache_rsp_data),
        .issue_en      (issue_en),
        .n_issue       (n_issue),
        .lane_valid    (if_valid_out),
        .lane_inst     (if_inst_out),
        .lane_pc       (if_pc_out),
        .lane_npc      (if_not_taken_NPC),
        .next_pc       (next_pc)
    );

    // In DRAIN fetch_pc still names the stale request, so the address stays put until it returns
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= FETCH;
            fetch_pc <= RESET_PC[PC_W-1:0];
            drain_pc <= '0;
        end else if (br_pred_wrong) begin
            if (icache_rsp_valid) begin
                fetch_pc <= br_recover_pc;
                state    <= FETCH;
            end else begin
                drain_pc <= br_recover_pc;
                state    <= DRAIN;
            end
        end else if (state == DRAIN) begin
            if (icache_rsp_valid) begin
                fetch_pc <= drain_pc;
                state    <= FETCH;
            end
        end else if (icache_rsp_valid) begin
            fetch_pc <= next_pc;
        end
    end

`ifdef FETCH_STATS_EN
    logic [32:0] fetched_sum;

    assign fetched_sum = {1'b0, stat_fetched} + 33'(n_issue);

    always_ff @(posedge clk) begin
        if (reset) begin
            stat_fetched        <= '0;
            stat_miss_cycles    <= '0;
            stat_ib_full_cycles <= '0;
            stat_redirects      <= '0;
        end else begin
            stat_fetched <= fetched_sum[32] ? '1 : fetched_sum[31:0];
            if (state == FETCH && !icache_rsp_valid && stat_miss_cycles != '1) begin
                stat_miss_cycles <= stat_miss_cycles + 32'd1;
            end
            if (icache_rsp_valid && ib_nAvai == 2'd0 && stat_ib_full_cycles != '1) begin
                stat_ib_full_cycles <= stat_ib_full_cycles + 32'd1;
            end
            if (br_pred_wrong && stat_redirects != '1) begin
                stat_redirects <= stat_redirects + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fetch_issue_unit.sv
// Directed testbench for fetch_issue_unit (default build, RESET_PC = 0x100).
module tb_fetch_issue_unit;

    localparam logic [31:0] NOOP = 32'h0000_0013;

    logic         clk = 1'b0;
    logic         reset;
    logic         br_pred_wrong;
    logic [63:0]  br_recover_pc;
    logic [1:0]   ib_nAvai;
    logic [1:0]   bp_pred_taken;
    logic [127:0] bp_pred_NPC;
    logic         icache_req;
    logic [63:0]  icache_addr;
    logic         icache_rsp_valid;
    logic [63:0]  icache_rsp_data;
    logic [63:0]  if_inst_out;
    logic [127:0] if_pc_out;
    logic [127:0] if_not_taken_NPC;
    logic [1:0]   if_valid_out;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fetch_issue_unit #(.RESET_PC(64'h100), .PC_W(64)) dut (
        .clk              (clk),
        .reset            (reset),
        .br_pred_wrong    (br_pred_wrong),
        .br_recover_pc    (br_recover_pc),
        .ib_nAvai         (ib_nAvai),
        .bp_pred_taken    (bp_pred_taken),
        .bp_pred_NPC      (bp_pred_NPC),
        .icache_req       (icache_req),
        .icache_addr      (icache_addr),
        .icache_rsp_valid (icache_rsp_valid),
        .icache_rsp_data  (icache_rsp_data),
        .if_inst_out      (if_inst_out),
        .if_pc_out        (if_pc_out),
        .if_not_taken_NPC (if_not_taken_NPC),
        .if_valid_out     (if_valid_out)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        br_pred_wrong    = 1'b0;
        br_recover_pc    = '0;
        ib_nAvai         = 2'd2;
        bp_pred_taken    = 2'b00;
        bp_pred_NPC      = '0;
        icache_rsp_valid = 1'b0;
        icache_rsp_data  = 64'hBBBB_0001_AAAA_0001;
    endtask

    // Redirect during a hit cycle: fetch_pc takes the recovery PC directly
    task automatic goto_pc(input logic [63:0] pc);
        br_pred_wrong = 1'b1; br_recover_pc = pc; icache_rsp_valid = 1'b1; #1;
        checks++;
        if (if_valid_out !== 2'b00) begin errors++; $display("FAIL goto_valid: got %b expected 00", if_valid_out); end
        tick();
        br_pred_wrong = 1'b0; icache_rsp_valid = 1'b0; #1;
        checks++;
        if (icache_addr !== {pc[63:3], 3'b000}) begin errors++; $display("FAIL goto_addr: got %h expected %h", icache_addr, {pc[63:3], 3'b000}); end
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b1;
        tick(); tick();
        checks++;
        if (if_valid_out !== 2'b00) begin errors++; $display("FAIL reset_valid: got %b expected 00", if_valid_out); end
        checks++;
        if (if_inst_out !== {NOOP, NOOP}) begin errors++; $display("FAIL reset_inst: got %h expected %h", if_inst_out, {NOOP, NOOP}); end
        reset = 1'b0; #1;
        checks++;
        if (icache_req !== 1'b1) begin errors++; $display("FAIL reset_req: got %b expected 1", icache_req); end
        checks++;
        if (icache_addr !== 64'h100) begin errors++; $display("FAIL reset_addr: got %h expected 100", icache_addr); end
    endtask

    task automatic test_dual_issue();
        icache_rsp_valid = 1'b1; icache_rsp_data = 64'h2222_2222_1111_1111; ib_nAvai = 2'd2; #1;
        checks++;
        if (if_valid_out !== 2'b11) begin errors++; $display("FAIL dual_valid: got %b expected 11", if_valid_out); end
        checks++;
        if (if_pc_out !== {64'h104, 64'h100}) begin errors++; $display("FAIL dual_pc: got %h expected 104/100", if_pc_out); end
        checks++;
        if (if_not_taken_NPC !== {64'h108, 64'h104}) begin errors++; $display("FAIL dual_npc: got %h expected 108/104", if_not_taken_NPC); end
        checks++;
        if (if_inst_out !== 64'h2222_2222_1111_1111) begin errors++; $display("FAIL dual_inst: got %h expected 2222222211111111", if_inst_out); end
        tick();
        icache_rsp_valid = 1'b0; #1;
        checks++;
        if (icache_addr !== 64'h108) begin errors++; $display("FAIL dual_next_addr: got %h expected 108", icache_addr); end
    endtask

    task automatic test_odd_slot();
        goto_pc(64'h104);
        icache_rsp_valid = 1'b1; icache_rsp_data = 64'hCAFE_0004_DEAD_0000; #1;
        checks++;
        if (if_valid_out !== 2'b01) begin errors++; $display("FAIL odd_valid: got %b expected 01", if_valid_out); end
        checks++;
        if (if_inst_out !== {NOOP, 32'hCAFE_0004}) begin errors++; $display("FAIL odd_inst: got %h expected %h", if_inst_out, {NOOP, 32'hCAFE_0004}); end
        checks++;
        if (if_pc_out[63:0] !== 64'h104) begin errors++; $display("FAIL odd_pc: got %h expected 104", if_pc_out[63:0]); end
        tick();
        icache_rsp_valid = 1'b0; #1;
        checks++;
        if (icache_addr !== 64'h108) begin errors++; $display("FAIL odd_next_addr: got %h expected 108", icache_addr); end
    endtask

    task automatic test_taken();
        goto_pc(64'h200);
        icache_rsp_valid = 1'b1; bp_pred_taken = 2'b01; bp_pred_NPC = {64'h999, 64'h400}; #1;
        checks++;
        if (if_valid_out !== 2'b01) begin errors++; $display("FAIL taken_valid: got %b expected 01", if_valid_out); end
        tick();
        bp_pred_taken = 2'b00; bp_pred_NPC = '0; #1;
        checks++;
        if (if_pc_out !== {64'h404, 64'h400}) begin errors++; $display("FAIL taken_target_pc: got %h expected 404/400", if_pc_out); end
        checks++;
        if (if_valid_out !== 2'b11) begin errors++; $display("FAIL taken_target_valid: got %b expected 11", if_valid_out); end
        tick();
        icache_rsp_valid = 1'b0; #1;
        checks++;
        if (icache_addr !== 64'h408) begin errors++; $display("FAIL taken_next_addr: got %h expected 408", icache_addr); end
    endtask

    task automatic test_ib_backpressure();
        goto_pc(64'h300);
        icache_rsp_valid = 1'b1; icache_rsp_data = 64'h3333_0304_3333_0300; ib_nAvai = 2'd1; #1;
        checks++;
        if (if_valid_out !== 2'b01 || if_pc_out[63:0] !== 64'h300) begin errors++; $display("FAIL ib1: got %b/%h expected 01/300", if_valid_out, if_pc_out[63:0]); end
        tick();
        ib_nAvai = 2'd0; #1;
        checks++;
        if (if_valid_out !== 2'b00 || icache_addr !== 64'h300) begin errors++; $display("FAIL ib0: got %b/%h expected 00/300", if_valid_out, icache_addr); end
        tick();
        ib_nAvai = 2'd2; #1;
        checks++;
        if (if_valid_out !== 2'b01 || if_pc_out[63:0] !== 64'h304) begin errors++; $display("FAIL ib2_odd: got %b/%h expected 01/304", if_valid_out, if_pc_out[63:0]); end
        checks++;
        if (if_inst_out[31:0] !== 32'h3333_0304) begin errors++; $display("FAIL ib2_inst: got %h expected 33330304", if_inst_out[31:0]); end
        tick();
        icache_rsp_valid = 1'b0; #1;
        checks++;
        if (icache_addr !== 64'h308) begin errors++; $display("FAIL ib_next_addr: got %h expected 308", icache_addr); end
    endtask

    task automatic test_miss_redirect();
        goto_pc(64'h500);
        tick();
        br_pred_wrong = 1'b1; br_recover_pc = 64'h800; #1;
        checks++;
        if (if_valid_out !== 2'b00) begin errors++; $display("FAIL miss_br_valid: got %b expected 00", if_valid_out); end
        tick();
        br_pred_wrong = 1'b0; #1;
        checks++;
        if (icache_req !== 1'b1 || icache_addr !== 64'h500) begin errors++; $display("FAIL drain_addr: got %b/%h expected 1/500", icache_req, icache_addr); end
        tick();
        icache_rsp_valid = 1'b1; #1;
        checks++;
        if (if_valid_out !== 2'b00) begin errors++; $display("FAIL drain_stale: got %b expected 00", if_valid_out); end
        tick();
        icache_rsp_valid = 1'b0; #1;
        checks++;
        if (icache_addr !== 64'h800) begin errors++; $display("FAIL drain_redirect_addr: got %h expected 800", icache_addr); end
        icache_rsp_valid = 1'b1; #1;
        checks++;
        if (if_valid_out !== 2'b11 || if_pc_out[63:0] !== 64'h800) begin errors++; $display("FAIL drain_resume: got %b/%h expected 11/800", if_valid_out, if_pc_out[63:0]); end
        tick();
        icache_rsp_valid = 1'b0;
    endtask

    task automatic test_redirect_hit();
        goto_pc(64'h600);
        goto_pc(64'h700);
        icache_rsp_valid = 1'b1; #1;
        checks++;
        if (if_pc_out[63:0] !== 64'h700 || if_valid_out !== 2'b11) begin errors++; $display("FAIL hit_redirect_pc: got %h/%b expected 700/11", if_pc_out[63:0], if_valid_out); end
        tick();
        icache_rsp_valid = 1'b0;
    endtask

    task automatic test_wrap();
        goto_pc(64'hFFFF_FFFF_FFFF_FFF8);
        icache_rsp_valid = 1'b1; #1;
        checks++;
        if (if_not_taken_NPC[127:64] !== 64'h0) begin errors++; $display("FAIL wrap_npc: got %h expected 0", if_not_taken_NPC[127:64]); end
        tick();
        icache_rsp_valid = 1'b0; #1;
        checks++;
        if (icache_addr !== 64'h0) begin errors++; $display("FAIL wrap_addr: got %h expected 0", icache_addr); end
    endtask

    initial begin
        test_reset();
        test_dual_issue();
        test_odd_slot();
        test_taken();
        test_ib_backpressure();
        test_miss_redirect();
        test_redirect_hit();
        test_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
